// File: rtl/lockin_polar_converter.sv
// ---------------------------------------------------------------------------
// lockin_polar_converter
// Converts each filtered lock-in (x, y) pair into magnitude and phase using an
// iterative vectoring CORDIC, one micro-rotation per clock.
//   IDLE -> PRE (quadrant fold) -> ITER (NUM_ITER steps) -> SCALE -> IDLE
// SCALE takes two cycles: the first registers the gain-compensation product,
// the second saturates it and publishes mag/phase with a one-cycle done pulse.
// Latency from the accepting clock edge k to done is k + NUM_ITER + 3.
// The arctangent table holds 2^23-per-pi values and is rounded to PHASE_BITS;
// it covers indices 0..22, so NUM_ITER must stay at or below 23.
// ---------------------------------------------------------------------------
module lockin_polar_converter #(
    parameter int NUM_BITS   = 24,
    parameter int PHASE_BITS = 24,
    parameter int NUM_ITER   = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  valid_i,
    input  logic [NUM_BITS-1:0]   x_i,
    input  logic [NUM_BITS-1:0]   y_i,
    output logic [NUM_BITS-1:0]   mag_o,
    output logic [PHASE_BITS-1:0] phase_o,
    output logic                  done_o,
    output logic                  busy_o,
    output logic                  overrun_o
);

    // Internal x/y carry two guard bits: fold plus CORDIC gain stays below 4x.
    localparam int W  = NUM_BITS + 2;
    // Product of W-bit x and the 17-bit signed gain constant.
    localparam int PW = W + 17;
    localparam int CW = $clog2(NUM_ITER + 1);

    localparam logic [CW-1:0] ITER_LAST = CW'(NUM_ITER - 1);
    // 1/K for the CORDIC gain K = 1.64676, in Q0.16.
    localparam logic signed [17:0] KINV = 18'sd39797;

    // +90 and -90 degrees as binary angles.
    localparam logic [PHASE_BITS-1:0] QUARTER_POS = {2'b01, {(PHASE_BITS-2){1'b0}}};
    localparam logic [PHASE_BITS-1:0] QUARTER_NEG = {2'b11, {(PHASE_BITS-2){1'b0}}};

    // Scaling of the 2^23-per-pi table to the configured phase width.
    localparam int          ASH    = (PHASE_BITS < 24) ? (24 - PHASE_BITS) : 0;
    localparam int          ALS    = (PHASE_BITS > 24) ? (PHASE_BITS - 24) : 0;
    localparam logic [63:0] AROUND = (64'd1 << ASH) >> 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRE   = 2'd1,
        ST_ITER  = 2'd2,
        ST_SCALE = 2'd3
    } state_t;

    // round(atan(2^-i) / pi * 2^(PHASE_BITS-1)) for micro-rotation i.
    function automatic logic [PHASE_BITS-1:0] atan_lut(input logic [CW-1:0] idx);
        logic [4:0]  sel;
        logic [31:0] v;
        logic [63:0] wide;
        sel = 5'(idx);
        case (sel)
            5'd0:    v = 32'd2097152;
            5'd1:    v = 32'd1238021;
            5'd2:    v = 32'd654136;
            5'd3:    v = 32'd332050;
            5'd4:    v = 32'd166669;
            5'd5:    v = 32'd83416;
            5'd6:    v = 32'd41718;
            5'd7:    v = 32'd20860;
            5'd8:    v = 32'd10430;
            5'd9:    v = 32'd5215;
            5'd10:   v = 32'd2608;
            5'd11:   v = 32'd1304;
            5'd12:   v = 32'd652;
            5'd13:   v = 32'd326;
            5'd14:   v = 32'd163;
            5'd15:   v = 32'd81;
            5'd16:   v = 32'd41;
            5'd17:   v = 32'd20;
            5'd18:   v = 32'd10;
            5'd19:   v = 32'd5;
            5'd20:   v = 32'd3;
            5'd21:   v = 32'd1;
            5'd22:   v = 32'd1;
            default: v = 32'd0;
        endcase
        wide = {32'd0, v} << ALS;
        if (ASH > 0) begin
            wide = (wide + AROUND) >> ASH;
        end else begin
            wide = wide;
        end
        return wide[PHASE_BITS-1:0];
    endfunction

    state_t                  state_r;
    logic [CW-1:0]           iter_r;
    logic signed [W-1:0]     x_r;
    logic signed [W-1:0]     y_r;
    logic [PHASE_BITS-1:0]   z_r;
    logic                    zero_r;
    logic                    scale_step_r;
    logic signed [PW-1:0]    prod_r;

    logic signed [W-1:0]     x_shift_s;
    logic signed [W-1:0]     y_shift_s;
    logic [PHASE_BITS-1:0]   atan_s;
    logic signed [PW-1:0]    prod_shift_s;
    logic [NUM_BITS-1:0]     mag_sat_s;

    // Micro-rotation operands and saturated, gain-compensated magnitude.
    always_comb begin
        x_shift_s    = x_r >>> iter_r;
        y_shift_s    = y_r >>> iter_r;
        atan_s       = atan_lut(iter_r);
        prod_shift_s = prod_r >>> 16;
        if (prod_shift_s[PW-1]) begin
            mag_sat_s = '0;
        end else if (|prod_shift_s[PW-2:NUM_BITS]) begin
            mag_sat_s = '1;
        end else begin
            mag_sat_s = prod_shift_s[NUM_BITS-1:0];
        end
    end

    // Conversion FSM with all outputs registered.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r      <= ST_IDLE;
            iter_r       <= '0;
            x_r          <= '0;
            y_r          <= '0;
            z_r          <= '0;
            zero_r       <= 1'b0;
            scale_step_r <= 1'b0;
            prod_r       <= '0;
            mag_o        <= '0;
            phase_o      <= '0;
            done_o       <= 1'b0;
            busy_o       <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (valid_i && (state_r != ST_IDLE)) begin
                overrun_o <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (valid_i) begin
                        x_r     <= W'($signed(x_i));
                        y_r     <= W'($signed(y_i));
                        z_r     <= '0;
                        zero_r  <= (x_i == '0) && (y_i == '0);
                        busy_o  <= 1'b1;
                        state_r <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    // Fold the left half-plane onto the right so CORDIC converges.
                    if (x_r[W-1] && !y_r[W-1]) begin
                        x_r <= y_r;
                        y_r <= -x_r;
                        z_r <= QUARTER_POS;
                    end else if (x_r[W-1] && y_r[W-1]) begin
                        x_r <= -y_r;
                        y_r <= x_r;
                        z_r <= QUARTER_NEG;
                    end
                    iter_r  <= '0;
                    state_r <= ST_ITER;
                end
                ST_ITER: begin
                    if (!y_r[W-1]) begin
                        x_r <= x_r + y_shift_s;
                        y_r <= y_r - x_shift_s;
                        z_r <= z_r + atan_s;
                    end else begin
                        x_r <= x_r - y_shift_s;
                        y_r <= y_r + x_shift_s;
                        z_r <= z_r - atan_s;
                    end
                    if (iter_r == ITER_LAST) begin
                        iter_r       <= '0;
                        scale_step_r <= 1'b0;
                        state_r      <= ST_SCALE;
                    end else begin
                        iter_r <= iter_r + CW'(1);
                    end
                end
                ST_SCALE: begin
                    if (!scale_step_r) begin
                        prod_r       <= PW'(x_r) * PW'(KINV);
                        scale_step_r <= 1'b1;
                    end else begin
                        mag_o        <= mag_sat_s;
                        // atan2(0,0) is reported as 0 rather than the accumulated angle.
                        phase_o      <= zero_r ? '0 : z_r;
                        done_o       <= 1'b1;
                        busy_o       <= 1'b0;
                        scale_step_r <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
